conv_sched: RTL and testbench
=============================

// Module: conv_sched
// PURPOSE
//  Sequencer for the 1-D systolic convolution array (WINDOW_SIZE taps x WEIGHT_SIZE filters).
//  - Slices an incoming sample stream into strided windows and feeds them to the array.
//  - Applies sink back-pressure to the array as its stall.
//  - Counts finished windows and reports completion of one convolution job.
//  - Sits between the feature-map DMA stream and the array; it holds no weights.
// PARAMETERS
//  WINDOW_SIZE  3   taps per window (array window width)
//  WEIGHT_SIZE  4   filters in the array (output lanes)
//  DATA_W       32  sample width
//  LEN_W        16  width of the length, stride and counter fields
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      synchronous, active-high reset
//  start        in   1                      job start pulse; sampled only in IDLE
//  cfg_len      in   LEN_W                  input samples N available for the job
//  cfg_stride   in   LEN_W                  window stride S
//  in_valid     in   1                      sample stream valid
//  in_data      in   DATA_W                 sample
//  in_ready     out  1                      sample accepted when in_valid & in_ready
//  win_valid    out  1                      window presented to the array
//  win_data     out  WINDOW_SIZE*DATA_W     window; tap 0 = oldest sample
//  win_stall    in   1                      array stall; window held while high
//  conv_valid   in   WEIGHT_SIZE            array per-lane result valid
//  out_ready    in   1                      downstream sink ready
//  arr_stall    out  1                      array stall request = ~out_ready while busy
//  busy         out  1                      job in progress
//  done         out  1                      1-cycle completion pulse
//  err          out  1                      valid with done: job rejected
// BEHAVIOUR
//  - Reset: state IDLE; all counters 0.
//    Outputs after reset: in_ready=0, win_valid=0, win_data=0, arr_stall=0, busy=0, done=0, err=0.
//  - Window count W = (N-WINDOW_SIZE)/S + 1, integer division.
//    Samples consumed: C = WINDOW_SIZE + (W-1)*S. Trailing N-C samples are left in the stream.
//  - IDLE: on start, latch cfg_len and cfg_stride.
//    - If N<WINDOW_SIZE or S==0: go to ERR.
//    - Otherwise compute W and go to FILL. busy rises the cycle after start.
//  - FILL: in_ready=1. Shift in WINDOW_SIZE samples, one per handshake.
//    - Each sample enters tap WINDOW_SIZE-1; the older taps shift down.
//    - After the last fill sample: win_valid=1 next cycle; go to RUN.
//  - RUN: a window is issued on a cycle with win_valid & ~win_stall.
//    - While win_valid & win_stall: win_valid and win_data are held stable.
//    - After an issue with windows remaining: win_valid=0.
//      in_ready=1 until S new samples have been shifted in; then win_valid=1 again.
//      If S>WINDOW_SIZE, the buffer only keeps the newest WINDOW_SIZE samples.
//    - in_ready=0 whenever win_valid=1. No sample is accepted in the issue cycle.
//    - After the W-th issue: go to DRAIN.
//  - Output counting, in RUN and DRAIN:
//    - A window is complete on a cycle with conv_valid[WEIGHT_SIZE-1] & out_ready.
//    - A stalled lane is not recounted.
//    - Completions can occur in RUN, concurrently with issues.
//  - DRAIN: when the completed count reaches W, go to DONE.
//  - DONE: done=1 for one cycle; busy falls; go to IDLE.
//  - ERR: done=1 and err=1 for one cycle; no samples consumed; go to IDLE.
//  - arr_stall = busy & ~out_ready.
//  - start while busy is ignored. W==1 is legal: FILL -> RUN -> DRAIN.
//  - Counters are LEN_W wide. cfg_len = 2^LEN_W-1 must not overflow.
//  - rst mid-job: immediate return to IDLE. In-flight array results are discarded.
//    The array itself must also be reset by the same rst.
// STRUCTURE
//  - Shared package cnn_pkg: state enum {IDLE,FILL,RUN,DRAIN,DONE,ERR};
//    WINDOW_SIZE and WEIGHT_SIZE defaults; window packing macro.
//  - Sub-module conv_window_buf: WINDOW_SIZE-deep shift register with shift-enable and clear.
//  - Top: FSM, sample/issue/completion counters, W computation
//    (sequential divider or repeated subtraction allowed in IDLE->FILL, max LEN_W cycles).
// TESTING
//  1. WINDOW_SIZE=3, N=8, S=1, samples 1..8, out_ready=1:
//     6 windows {1,2,3}..{6,7,8}; 6 completions; done one cycle after the 6th.
//  2. N=8, S=2: windows {1,2,3},{3,4,5},{5,6,7}; sample 8 not consumed (in_ready=0).
//  3. N=2 or S=0: done=err=1 one cycle after start; in_ready never asserted.
//  4. win_stall high 5 cycles mid-RUN: win_data stable; no samples accepted; window count unchanged.
//  5. out_ready low 10 cycles during DRAIN: arr_stall=1; no completions counted; done only after W counted.
//  6. rst asserted in RUN: next cycle busy=0, win_valid=0, in_ready=0;
//     a new start runs test 1 cleanly.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and defaults for the convolution-array sequencer.
package conv_sched_pkg;

    localparam int unsigned WINDOW_SIZE_DEF = 3;
    localparam int unsigned WEIGHT_SIZE_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/conv_sched_if.sv
// Job control, sample stream, window and array-result signals of conv_sched.
interface conv_sched_if
    import conv_sched_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = WINDOW_SIZE_DEF,
    parameter int unsigned WEIGHT_SIZE = WEIGHT_SIZE_DEF,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEN_W       = 16
);

    logic                          start;
    logic [LEN_W-1:0]              cfg_len;
    logic [LEN_W-1:0]              cfg_stride;
    logic                          in_valid;
    logic [DATA_W-1:0]             in_data;
    logic                          in_ready;
    logic                          win_valid;
    logic [WINDOW_SIZE*DATA_W-1:0] win_data;
    logic                          win_stall;
    logic [WEIGHT_SIZE-1:0]        conv_valid;
    logic                          out_ready;
    logic                          arr_stall;
    logic                          busy;
    logic                          done;
    logic                          err;

    modport slave (
        input  start, cfg_len, cfg_stride, in_valid, in_data, win_stall, conv_valid, out_ready,
        output in_ready, win_valid, win_data, arr_stall, busy, done, err
    );

    modport master (
        output start, cfg_len, cfg_stride, in_valid, in_data, win_stall, conv_valid, out_ready,
        input  in_ready, win_valid, win_data, arr_stall, busy, done, err
    );

endinterface

// File: rtl/conv_window_buf.sv
// Window shift register: new samples enter the top tap, tap 0 holds the oldest.
module conv_window_buf
    import conv_sched_pkg::*;
#(
    parameter int unsigned DEPTH  = WINDOW_SIZE_DEF,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    shift_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [DEPTH*DATA_W-1:0] taps_o
);

    logic [DEPTH-1:0][DATA_W-1:0] taps_q, taps_d;

    always_comb begin
        taps_d = taps_q;
        if (clr_i) begin
            taps_d = '0;
        end else if (shift_i) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                taps_d[i] = taps_q[i+1];
            end
            taps_d[DEPTH-1] = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) taps_q <= '0;
        else     taps_q <= taps_d;
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/conv_sched.sv
// Sequencer: slices a sample stream into strided windows for the systolic array
// and counts finished windows to signal job completion.
module conv_sched
    import conv_sched_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE = WINDOW_SIZE_DEF,
    parameter int unsigned WEIGHT_SIZE = WEIGHT_SIZE_DEF,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEN_W       = 16
) (
    input logic         clk,
    input logic         rst,
    conv_sched_if.slave bus
);

    state_t            state_q;
    logic [LEN_W-1:0]  len_q, stride_q, cons_q, step_q, issued_q, cmpl_q;
    logic              in_ready_q, win_valid_q, busy_q, done_q, err_q;

    logic              accept, issue, complete, start_ok, more;
    logic [LEN_W:0]    cmpl_next;

    assign accept    = bus.in_valid & in_ready_q;
    assign issue     = win_valid_q & ~bus.win_stall;
    assign complete  = bus.conv_valid[WEIGHT_SIZE-1] & bus.out_ready &
                       ((state_q == RUN) || (state_q == DRAIN));
    assign start_ok  = (bus.cfg_len >= LEN_W'(WINDOW_SIZE)) && (bus.cfg_stride != '0);
    // Another window exists iff S more samples are still available; the issue
    // count then equals W, so no divider is needed and DRAIN compares against it.
    assign more      = ({1'b0, cons_q} + {1'b0, stride_q}) <= {1'b0, len_q};
    assign cmpl_next = {1'b0, cmpl_q} + (LEN_W+1)'(complete);

    conv_window_buf #(
        .DEPTH  (WINDOW_SIZE),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   ((state_q == IDLE) && bus.start),
        .shift_i (accept),
        .data_i  (bus.in_data),
        .taps_o  (bus.win_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            stride_q    <= '0;
            cons_q      <= '0;
            step_q      <= '0;
            issued_q    <= '0;
            cmpl_q      <= '0;
            in_ready_q  <= 1'b0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept)   cons_q <= cons_q + 1'b1;
            if (complete) cmpl_q <= cmpl_next[LEN_W-1:0];
            unique case (state_q)
                IDLE: if (bus.start) begin
                    len_q    <= bus.cfg_len;
                    stride_q <= bus.cfg_stride;
                    cons_q   <= '0;
                    step_q   <= '0;
                    issued_q <= '0;
                    cmpl_q   <= '0;
                    if (!start_ok) begin
                        state_q <= ERR;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        state_q    <= FILL;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                FILL: if (accept) begin
                    if (step_q == LEN_W'(WINDOW_SIZE - 1)) begin
                        step_q      <= '0;
                        in_ready_q  <= 1'b0;
                        win_valid_q <= 1'b1;
                        state_q     <= RUN;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        issued_q    <= issued_q + 1'b1;
                        win_valid_q <= 1'b0;
                        if (more) begin
                            in_ready_q <= 1'b1;
                            step_q     <= '0;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (accept) begin
                        if (step_q == stride_q - 1'b1) begin
                            step_q      <= '0;
                            in_ready_q  <= 1'b0;
                            win_valid_q <= 1'b1;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                DRAIN: if (cmpl_next >= {1'b0, issued_q}) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.win_valid = win_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.arr_stall = busy_q & ~bus.out_ready;

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: directed job table plus random jobs against a window/count model.
module tb_conv_sched;

    localparam int unsigned WS = 3;
    localparam int unsigned WT = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 16;

    typedef struct {
        int unsigned n;
        int unsigned s;
        bit          rnd;
        int          stall_at;
        int          rst_at;
        bit          drain_hold;
        bit          exp_err;
        int unsigned exp_w;
        int unsigned exp_c;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    conv_sched_if #(.WINDOW_SIZE(WS), .WEIGHT_SIZE(WT), .DATA_W(DW), .LEN_W(LW)) bus();

    conv_sched #(
        .WINDOW_SIZE (WS),
        .WEIGHT_SIZE (WT),
        .DATA_W      (DW),
        .LEN_W       (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    int unsigned      acc, issued, cmpl, pend;
    logic [DW-1:0]    base;
    bit               done_due, prev_stall, lane_last;
    logic [WS*DW-1:0] prev_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_job(input int unsigned n, input int unsigned s,
                                    output bit e, output int unsigned w, output int unsigned c);
        e = (n < WS) || (s == 0);
        w = e ? 0 : (n - WS) / s + 1;
        c = e ? 0 : WS + (w - 1) * s;
    endfunction

    function automatic logic [DW-1:0] smp(input int unsigned i);
        return base + DW'(i) + 1;
    endfunction

    function automatic logic [WS*DW-1:0] exp_win(input int unsigned k, input int unsigned s);
        logic [WS*DW-1:0] w;
        w = '0;
        for (int unsigned t = 0; t < WS; t++) w[t*DW +: DW] = smp(k * s + t);
        return w;
    endfunction

    task automatic run_job(input vec_t v);
        int unsigned budget, stall_left, hold_left;
        bit          stall_used, hold_used;
        acc = 0; issued = 0; cmpl = 0; pend = 0;
        done_due = 0; prev_stall = 0; lane_last = 0;
        base = v.rnd ? DW'($urandom) : '0;
        stall_left = 0; hold_left = 0; stall_used = 0; hold_used = 0;
        budget = 300 + 16 * ((v.n > 1000) ? 1000 : v.n);

        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.cfg_len    = LW'(v.n);
        bus.cfg_stride = LW'(v.s);
        bus.in_valid   = 1'b0;
        bus.win_stall  = 1'b0;
        bus.out_ready  = 1'b1;
        bus.conv_valid = '0;

        if (v.exp_err) begin
            for (int unsigned k = 1; k <= 3; k++) begin
                @(posedge clk); #1;
                bus.start    = 1'b0;
                bus.in_valid = 1'b1;
                bus.in_data  = DW'($urandom);
                check(k == 1 ? "err_pulse" : "err_after",
                      {bus.done, bus.err, bus.busy, bus.in_ready},
                      (k == 1) ? 4'b1100 : 4'b0000);
            end
            bus.in_valid = 1'b0;
            return;
        end

        for (int unsigned cyc = 1; ; cyc++) begin
            @(posedge clk); #1;
            if (v.rst_at >= 0 && int'(issued) == v.rst_at) begin
                rst = 1'b1;
                bus.start = 1'b0;
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_mid", {bus.busy, bus.win_valid, bus.in_ready, bus.done}, 4'b0000);
                return;
            end
            // start pulses while busy must be ignored
            bus.start      = v.rnd && ($urandom_range(0, 7) == 0);
            bus.cfg_len    = LW'($urandom);
            bus.cfg_stride = LW'($urandom);
            bus.in_valid   = (acc < v.n) && (!v.rnd || $urandom_range(0, 3) != 0);
            bus.in_data    = (acc < v.n) ? smp(acc) : DW'($urandom);
            if (stall_left > 0) begin
                bus.win_stall = 1'b1;
                stall_left--;
            end else if (v.stall_at >= 0 && !stall_used && int'(issued) == v.stall_at && bus.win_valid) begin
                stall_used = 1; stall_left = 4; bus.win_stall = 1'b1;
            end else begin
                bus.win_stall = v.rnd && ($urandom_range(0, 3) == 0);
            end
            if (hold_left > 0) begin
                bus.out_ready = 1'b0;
                hold_left--;
            end else if (v.drain_hold && !hold_used && issued == v.exp_w) begin
                hold_used = 1; hold_left = 9; bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = !v.rnd || ($urandom_range(0, 3) != 0);
            end
            lane_last      = (pend > 0) && (!v.rnd || $urandom_range(0, 1) == 1);
            bus.conv_valid = {lane_last, (WT-1)'($urandom)};

            @(negedge clk);
            check("busy", bus.busy, !done_due);
            check("done_err", {bus.done, bus.err}, {done_due, 1'b0});
            check("arr_stall", bus.arr_stall, !done_due && !bus.out_ready);
            check("rdy_vs_win", bus.in_ready & bus.win_valid, 1'b0);
            if (prev_stall) check("stall_hold", {bus.win_valid, bus.win_data}, {1'b1, prev_data});
            prev_stall = bus.win_valid & bus.win_stall;
            prev_data  = bus.win_data;
            if (bus.done) begin
                check("windows", issued, v.exp_w);
                check("consumed", acc, v.exp_c);
                break;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            done_due = 0;
            if (lane_last && bus.out_ready) begin
                pend--;
                cmpl++;
                done_due = (cmpl == v.exp_w);
            end
            if (bus.win_valid && !bus.win_stall) begin
                check("window", bus.win_data, exp_win(issued, v.s));
                issued++;
                pend++;
            end
            if (cyc >= budget) begin
                checks++;
                failures++;
                $display("FAIL timeout: no done after %0d cycles (issued=%0d consumed=%0d)", cyc, issued, acc);
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.conv_valid = '0;
    endtask

    initial begin
        vec_t v;
        vec_t vecs[$];
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.cfg_len    = '0;
        bus.cfg_stride = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.win_stall  = 1'b0;
        bus.conv_valid = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              {bus.in_ready, bus.win_valid, bus.win_data, bus.arr_stall, bus.busy, bus.done, bus.err}, '0);
        rst = 1'b0;

        //              n      s      rnd stall rst drain err  W  C
        vecs.push_back('{8,     1,     0,  -1,   -1, 0,    0,   6, 8});
        vecs.push_back('{8,     2,     0,  -1,   -1, 0,    0,   3, 7});
        vecs.push_back('{2,     1,     0,  -1,   -1, 0,    1,   0, 0});
        vecs.push_back('{8,     0,     0,  -1,   -1, 0,    1,   0, 0});
        vecs.push_back('{8,     1,     0,   2,   -1, 0,    0,   6, 8});
        vecs.push_back('{8,     2,     0,  -1,   -1, 1,    0,   3, 7});
        vecs.push_back('{8,     1,     0,  -1,    3, 0,    0,   6, 8});
        vecs.push_back('{8,     1,     0,  -1,   -1, 0,    0,   6, 8});
        vecs.push_back('{3,     1,     0,  -1,   -1, 0,    0,   1, 3});
        vecs.push_back('{8,     5,     0,  -1,   -1, 0,    0,   2, 8});
        vecs.push_back('{10,    4,     0,  -1,   -1, 0,    0,   2, 7});
        vecs.push_back('{65535, 65535, 0,  -1,   -1, 0,    0,   1, 3});
        vecs.push_back('{0,     0,     0,  -1,   -1, 0,    1,   0, 0});

        for (int i = 0; i < 24; i++) begin
            v.n = $urandom_range(0, 30);
            v.s = $urandom_range(0, 7);
            v.rnd = 1'b1;
            v.stall_at = -1;
            v.rst_at = -1;
            v.drain_hold = 1'b0;
            ref_job(v.n, v.s, v.exp_err, v.exp_w, v.exp_c);
            vecs.push_back(v);
        end

        foreach (vecs[i]) run_job(vecs[i]);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
